// File: rtl/mpx_pkg.sv
// rtl/mpx_pkg.sv - shared constants, FSM state type and helpers for the MPX gain scheduler
package mpx_pkg;

  // Audio sample width (signed) and unsigned gain-code width
  localparam int NBITS     = 18;
  localparam int K_NBITS   = 4;
  // Product width of the shared NBITS x (K_NBITS+1) signed multiplier
  localparam int MULT_RW   = NBITS + K_NBITS + 1;
  // The gain code carries three fractional bits; the product is rescaled by this shift
  localparam int RES_SHIFT = 3;
  // Cycles waited for mult_ready per multiply before the operation is abandoned
  localparam int TIMEOUT   = 64;

  // Sequencer states: latch, start/wait for the sum multiply, start/wait for the
  // difference multiply, then publish both results
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ST_S = 3'd1,
    WT_S = 3'd2,
    ST_D = 3'd3,
    WT_D = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/mpx_gain_sat.sv
// rtl/mpx_gain_sat.sv - rescales a multiplier product to sample width; saturates when GAIN_SAT_EN is defined
module mpx_gain_sat #(
  parameter int NBITS   = mpx_pkg::NBITS,
  parameter int K_NBITS = mpx_pkg::K_NBITS
) (
  input  logic signed [NBITS+K_NBITS:0] product,
  output logic        [NBITS-1:0]       result
);
  import mpx_pkg::*;

`ifdef GAIN_SAT_EN
  // Largest and smallest representable sample, sign-extended to product width
  localparam logic signed [NBITS+K_NBITS:0] MAX_V =
    {{(K_NBITS+2){1'b0}}, {(NBITS-1){1'b1}}};
  localparam logic signed [NBITS+K_NBITS:0] MIN_V =
    {{(K_NBITS+2){1'b1}}, {(NBITS-1){1'b0}}};

  logic signed [NBITS+K_NBITS:0] shifted;

  assign shifted = product >>> RES_SHIFT;

  // Clamp the rescaled product into the signed sample range
  always_comb begin
    result = shifted[NBITS-1:0];
    if (shifted > MAX_V) begin
      result = {1'b0, {(NBITS-1){1'b1}}};
    end else if (shifted < MIN_V) begin
      result = {1'b1, {(NBITS-1){1'b0}}};
    end
  end
`else
  // Sign bits above the slice and the fractional bits below it are discarded
  logic unused_bits;

  assign unused_bits = ^{product[NBITS+K_NBITS:NBITS+K_NBITS-1], product[RES_SHIFT-1:0]};

  // Plain slice; an out-of-range product wraps
  always_comb begin
    result = product[NBITS+K_NBITS-2:RES_SHIFT];
  end
`endif

endmodule

// File: rtl/mpx_gain_scheduler.sv
// rtl/mpx_gain_scheduler.sv - time-multiplexes one external multiplier for the Ks/Kd gains; optional GAIN_SAT_EN
module mpx_gain_scheduler #(
  parameter int NBITS   = mpx_pkg::NBITS,
  parameter int K_NBITS = mpx_pkg::K_NBITS,
  parameter int TIMEOUT = mpx_pkg::TIMEOUT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enableclk,
  input  logic signed [NBITS-1:0]       LEFTin,
  input  logic signed [NBITS-1:0]       RIGHTin,
  input  logic        [K_NBITS-1:0]     Ks,
  input  logic        [K_NBITS-1:0]     Kd,
  output logic                          mult_start,
  output logic signed [NBITS-1:0]       mult_a,
  output logic signed [K_NBITS:0]       mult_b,
  input  logic                          mult_ready,
  input  logic signed [NBITS+K_NBITS:0] mult_r,
  output logic signed [NBITS-1:0]       SUMout,
  output logic signed [NBITS-1:0]       DIFout,
  output logic                          out_valid,
  output logic                          overrun,
  output logic                          timeout
);
  import mpx_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT);

  state_t                  state;
  logic [CW-1:0]           wait_cnt;

  // One extra bit so L+R and L-R never overflow before halving
  logic signed [NBITS:0]   sum_w;
  logic signed [NBITS:0]   dif_w;
  logic                    unused_lsbs;

  // Operands latched at the strobe; later input changes do not disturb the operation
  logic [NBITS-1:0]        sum_q;
  logic [NBITS-1:0]        dif_q;
  logic [K_NBITS-1:0]      ks_q;
  logic [K_NBITS-1:0]      kd_q;

  // Rescaled products held until both are ready to publish together
  logic [NBITS-1:0]        sum_res;
  logic [NBITS-1:0]        dif_res;
  logic [NBITS-1:0]        sat_res;

  assign sum_w = {LEFTin[NBITS-1], LEFTin} + {RIGHTin[NBITS-1], RIGHTin};
  assign dif_w = {LEFTin[NBITS-1], LEFTin} - {RIGHTin[NBITS-1], RIGHTin};

  // Halving drops the LSBs of the widened sum and difference
  assign unused_lsbs = sum_w[0] ^ dif_w[0];

  // A single rescaler serves both captures; only one multiply is ever in flight
  mpx_gain_sat #(
    .NBITS   (NBITS),
    .K_NBITS (K_NBITS)
  ) u_gain_sat (
    .product (mult_r),
    .result  (sat_res)
  );

  // Sequencer: latch, sum multiply, difference multiply, publish; registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      sum_q      <= '0;
      dif_q      <= '0;
      ks_q       <= '0;
      kd_q       <= '0;
      sum_res    <= '0;
      dif_res    <= '0;
      mult_start <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
      SUMout     <= '0;
      DIFout     <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      mult_start <= 1'b0;
      out_valid  <= 1'b0;

      // A strobe outside IDLE (DONE included) is dropped, never queued
      if (enableclk && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (enableclk) begin
            sum_q <= sum_w[NBITS:1];
            dif_q <= dif_w[NBITS:1];
            ks_q  <= Ks;
            kd_q  <= Kd;
            state <= ST_S;
          end
        end

        ST_S: begin
          mult_start <= 1'b1;
          mult_a     <= sum_q;
          mult_b     <= {1'b0, ks_q};
          wait_cnt   <= '0;
          state      <= WT_S;
        end

        // First wait cycle skips ready: it may still be high from the previous product
        WT_S: begin
          if ((wait_cnt != '0) && mult_ready) begin
            sum_res <= sat_res;
            state   <= ST_D;
          end else if (wait_cnt == WAIT_LIMIT) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_D: begin
          mult_start <= 1'b1;
          mult_a     <= dif_q;
          mult_b     <= {1'b0, kd_q};
          wait_cnt   <= '0;
          state      <= WT_D;
        end

        WT_D: begin
          if ((wait_cnt != '0) && mult_ready) begin
            dif_res <= sat_res;
            state   <= DONE;
          end else if (wait_cnt == WAIT_LIMIT) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        DONE: begin
          SUMout    <= sum_res;
          DIFout    <= dif_res;
          out_valid <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpx_gain_scheduler.sv
// tb/tb_mpx_gain_scheduler.sv - self-checking bench for mpx_gain_scheduler with a behavioural multiplier
module tb_mpx_gain_scheduler;

  logic        clock;
  logic        reset;
  logic        enableclk;
  logic [17:0] LEFTin;
  logic [17:0] RIGHTin;
  logic [3:0]  Ks;
  logic [3:0]  Kd;
  logic        mult_start;
  logic [17:0] mult_a;
  logic [4:0]  mult_b;
  logic        mult_ready;
  logic [22:0] mult_r;
  logic [17:0] SUMout;
  logic [17:0] DIFout;
  logic        out_valid;
  logic        overrun;
  logic        timeout;

  int passed;
  int total;
  int n_start;
  int n_valid;
  int stub_lat;
  bit stub_stuck;
  bit stub_busy;
  int stub_cnt;

  mpx_gain_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .enableclk  (enableclk),
    .LEFTin     (LEFTin),
    .RIGHTin    (RIGHTin),
    .Ks         (Ks),
    .Kd         (Kd),
    .mult_start (mult_start),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_ready (mult_ready),
    .mult_r     (mult_r),
    .SUMout     (SUMout),
    .DIFout     (DIFout),
    .out_valid  (out_valid),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sequential multiplier model: product ready stub_lat+1 cycles after start is seen
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      stub_busy  <= 1'b0;
      stub_cnt   <= 0;
      mult_ready <= 1'b0;
      mult_r     <= '0;
    end else if (mult_start) begin
      mult_ready <= 1'b0;
      if (!stub_stuck) begin
        stub_busy <= 1'b1;
        stub_cnt  <= stub_lat;
        mult_r    <= 23'($signed(mult_a) * $signed(mult_b));
      end
    end else if (stub_busy) begin
      if (stub_cnt <= 1) begin
        mult_ready <= 1'b1;
        stub_busy  <= 1'b0;
      end
      stub_cnt <= stub_cnt - 1;
    end
  end

  // Pulse counters, sampled mid-cycle
  always @(negedge clock) begin
    if (mult_start) n_start <= n_start + 1;
    if (out_valid)  n_valid <= n_valid + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference: floor((a +/- b)/2) * k, divided by 8 (floor), then wrapped or clamped to 18 bits
  function automatic int ref_gain(input int a, input int b, input int k, input bit is_dif);
    int s;
    int q;
    s = is_dif ? (a - b) : (a + b);
    s = s >>> 1;
    q = (s * k) >>> 3;
`ifdef GAIN_SAT_EN
    if (q > 131071) q = 131071;
    else if (q < -131072) q = -131072;
`else
    q = q & 32'h3FFFF;
    if (q >= 131072) q = q - 262144;
`endif
    return q;
  endfunction

  function automatic int rand_sample();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  task automatic run_sample(input int l, input int r, input int ks, input int kd, input int lat,
                            input int extra, input bit scramble, input string tag);
    int cyc;
    int s0;
    int v0;
    int exp_s;
    int exp_d;
    int exp_lat;
    stub_lat = lat;
    LEFTin   = 18'(l);
    RIGHTin  = 18'(r);
    Ks       = 4'(ks);
    Kd       = 4'(kd);
    exp_s    = ref_gain(l, r, ks, 1'b0);
    exp_d    = ref_gain(l, r, kd, 1'b1);
    exp_lat  = 2 * ((lat + 1) + 2) + 2;
    s0       = n_start;
    v0       = n_valid;
    cyc      = 0;
    @(negedge clock);
    enableclk = 1'b1;
    while (out_valid !== 1'b1 && cyc < 400) begin
      @(negedge clock);
      cyc++;
      enableclk = (extra != 0) && (cyc == extra);
      if (scramble) begin
        LEFTin  = 18'($urandom);
        RIGHTin = 18'($urandom);
        Ks      = 4'($urandom);
        Kd      = 4'($urandom);
      end
    end
    enableclk = 1'b0;
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_sum"}, int'($signed(SUMout)), exp_s);
    chk({tag, "_dif"}, int'($signed(DIFout)), exp_d);
    repeat (2 * lat + 12) @(negedge clock);
    chk({tag, "_starts"}, n_start - s0, 2);
    chk({tag, "_valids"}, n_valid - v0, 1);
  endtask

  initial begin
    int cyc;
    int v0;
    int held;
    passed     = 0;
    total      = 0;
    n_start    = 0;
    n_valid    = 0;
    stub_lat   = 3;
    stub_stuck = 1'b0;
    reset      = 1'b0;
    enableclk  = 1'b0;
    LEFTin     = '0;
    RIGHTin    = '0;
    Ks         = '0;
    Kd         = '0;

    // Reset held for three cycles
    repeat (3) @(negedge clock);
    chk("rst_sum", int'(SUMout), 0);
    chk("rst_dif", int'(DIFout), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_flags", int'({overrun, timeout}), 0);
    chk("rst_mult_ab", int'({mult_a, mult_b}), 0);
    chk("rst_no_start", n_start, 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_no_start", n_start, 0);

    // Nominal sample
    run_sample(1000, 200, 8, 8, 3, 0, 1'b0, "nominal");
    chk("nominal_sum_abs", int'($signed(SUMout)), 600);
    chk("nominal_dif_abs", int'($signed(DIFout)), 400);

    // Full-scale inputs with the largest gain
    run_sample(131071, 131071, 15, 15, 2, 0, 1'b0, "extreme");
`ifdef GAIN_SAT_EN
    chk("extreme_sum_abs", int'($signed(SUMout)), 131071);
`else
    chk("extreme_sum_abs", int'($signed(SUMout)), -16386);
`endif
    run_sample(-131072, 131071, 15, 15, 1, 0, 1'b0, "extreme_neg");

    // Random samples, inputs scrambled while the operation is in flight
    for (int i = 0; i < 8; i++) begin
      run_sample(rand_sample(), rand_sample(), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(1, 6)), 0, 1'b1, "random");
    end
    chk("random_no_overrun", int'(overrun), 0);

    // Multiplier never answers
    stub_stuck = 1'b1;
    v0   = n_valid;
    held = int'($signed(SUMout));
    @(negedge clock);
    enableclk = 1'b1;
    cyc = 0;
    repeat (66) begin
      @(negedge clock);
      cyc++;
      enableclk = 1'b0;
    end
    chk("timeout_not_yet", int'(timeout), 0);
    @(negedge clock);
    chk("timeout_set", int'(timeout), 1);
    repeat (5) @(negedge clock);
    chk("timeout_no_valid", n_valid - v0, 0);
    chk("timeout_sum_held", int'($signed(SUMout)), held);
    stub_stuck = 1'b0;
    run_sample(rand_sample(), rand_sample(), 5, 11, 2, 0, 1'b0, "after_timeout");
    chk("after_timeout_no_overrun", int'(overrun), 0);
    chk("timeout_sticky", int'(timeout), 1);

    // Second strobe five cycles after the first
    run_sample(-5000, 3000, 9, 4, 4, 5, 1'b1, "overrun");
    chk("overrun_set", int'(overrun), 1);

    // Asynchronous reset while waiting on the difference product
    stub_lat = 3;
    LEFTin   = 18'(777);
    RIGHTin  = 18'(-333);
    Ks       = 4'd7;
    Kd       = 4'd9;
    @(negedge clock);
    enableclk = 1'b1;
    cyc = 0;
    while (cyc < 9) begin
      @(negedge clock);
      cyc++;
      enableclk = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    chk("areset_sum", int'(SUMout), 0);
    chk("areset_dif", int'(DIFout), 0);
    chk("areset_start", int'(mult_start), 0);
    chk("areset_mult_ab", int'({mult_a, mult_b}), 0);
    chk("areset_overrun", int'(overrun), 0);
    chk("areset_timeout", int'(timeout), 0);
    @(negedge clock);
    reset = 1'b1;
    run_sample(777, -333, 7, 9, 3, 0, 1'b0, "post_reset");
    chk("post_reset_no_overrun", int'(overrun), 0);

    // Strobe arriving exactly in DONE is an overrun and is not queued
    run_sample(20000, -4000, 12, 3, 2, 2 * (2 + 3) + 2 - 1, 1'b0, "done_strobe");
    chk("done_strobe_overrun", int'(overrun), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
